// File: rtl/sargantana_icache_ifill_responder.sv
// Memory-side IFILL responder: takes one refill request, reads the line from memory
// as N_BEATS in-order beats and returns it as a single-cycle response pulse.
module sargantana_icache_ifill_responder #(
  parameter int unsigned ADDR_WIDTH = 40,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned BEAT_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  ifill_req_valid_i,
  input  logic [ADDR_WIDTH-1:0] ifill_req_paddr_i,
  input  logic                  ifill_req_kill_i,
  output logic                  ifill_sent_ack_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [BEAT_WIDTH-1:0] mem_rsp_data_i,
  input  logic                  mem_rsp_error_i,
  output logic                  ifill_resp_valid_o,
  output logic                  ifill_resp_ack_o,
  output logic [LINE_WIDTH-1:0] ifill_resp_data_o,
  output logic                  ifill_resp_error_o,
  output logic                  busy_o
);

  localparam int unsigned NBeats = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned CntW   = $clog2(NBeats);
  localparam int unsigned OffW   = $clog2(LINE_WIDTH / 8);

  typedef enum logic [2:0] {StIdle, StReq, StCollect, StDrain, StResp} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  ack_q, ack_d;
  logic [LINE_WIDTH-1:0] data_q, data_d;
  logic                  last_beat;

  assign last_beat = mem_rsp_valid_i && (cnt_q == CntW'(NBeats - 1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    data_d  = data_q;
    ack_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ifill_req_valid_i) begin
          addr_d  = {ifill_req_paddr_i[ADDR_WIDTH-1:OffW], {OffW{1'b0}}};
          cnt_d   = '0;
          err_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        // A kill racing the handshake still has beats coming back, so they get drained.
        if (mem_req_ready_i) begin
          state_d = ifill_req_kill_i ? StDrain : StCollect;
        end else if (ifill_req_kill_i) begin
          state_d = StIdle;
        end
      end
      StCollect: begin
        if (mem_rsp_valid_i) begin
          for (int unsigned k = 0; k < NBeats; k++) begin
            if (cnt_q == CntW'(k)) data_d[k*BEAT_WIDTH +: BEAT_WIDTH] = mem_rsp_data_i;
          end
          err_d = err_q | mem_rsp_error_i;
          cnt_d = cnt_q + CntW'(1);
        end
        if (last_beat) begin
          state_d = ifill_req_kill_i ? StIdle : StResp;
        end else if (ifill_req_kill_i) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (mem_rsp_valid_i) cnt_d = cnt_q + CntW'(1);
        if (last_beat) state_d = StIdle;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
    end
  end

  assign ifill_sent_ack_o   = ack_q;
  assign mem_req_valid_o    = (state_q == StReq);
  assign mem_req_addr_o     = addr_q;
  assign ifill_resp_valid_o = (state_q == StResp);
  assign ifill_resp_ack_o   = (state_q == StResp);
  assign ifill_resp_error_o = (state_q == StResp) && err_q;
  assign ifill_resp_data_o  = data_q;
  assign busy_o             = (state_q != StIdle);

endmodule

// File: doc/sargantana_icache_ifill_responder.md
# sargantana_icache_ifill_responder

Memory-side end of the instruction-cache IFILL protocol. Accepts a single-outstanding refill request from the icache controller, acknowledges it with `ifill_sent_ack_o`, fetches the line from the next memory level as `N_BEATS` beats, and assembles them into one line. It returns that line with a one-cycle `ifill_resp_valid_o`/`ifill_resp_ack_o` pulse. It sits between the icache controller/datapath and the L2/NoC adapter.

## Interface
- `ADDR_WIDTH`, default 40: physical address width.
- `LINE_WIDTH`, default 128: cache line width in bits.
- `BEAT_WIDTH`, default 32: memory beat width. `N_BEATS = LINE_WIDTH/BEAT_WIDTH`, must be a power of 2 and at least 2.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low. Ports:
- `clk_i`  in  1  clock
- `rstn_i`  in  1  asynchronous active-low reset
- `ifill_req_valid_i`  in  1  refill request from icache controller
- `ifill_req_paddr_i`  in  ADDR_WIDTH  physical address of the missing fetch
- `ifill_req_kill_i`  in  1  abandon the in-flight request; no response is returned
- `ifill_sent_ack_o`  out  1  one-cycle pulse: request captured
- `mem_req_valid_o`  out  1  line read request to memory
- `mem_req_ready_i`  in  1  memory accepts the request
- `mem_req_addr_o`  out  ADDR_WIDTH  line-aligned address
- `mem_rsp_valid_i`  in  1  beat valid, in order, lowest beat first
- `mem_rsp_data_i`  in  BEAT_WIDTH  beat data
- `mem_rsp_error_i`  in  1  beat carries a bus error
- `ifill_resp_valid_o`  out  1  one-cycle pulse: line data valid
- `ifill_resp_ack_o`  out  1  asserted together with `ifill_resp_valid_o`
- `ifill_resp_data_o`  out  LINE_WIDTH  assembled line; beat k occupies bits [k*BEAT_WIDTH +: BEAT_WIDTH]
- `ifill_resp_error_o`  out  1  OR of all beat errors, valid with the response
- `busy_o`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, REQ, COLLECT, DRAIN, RESP.
- IDLE: `ifill_req_valid_i` captures the line-aligned address, `paddr & ~(LINE_WIDTH/8-1)`. The FSM moves to REQ and clears the beat counter and the error flag.
- REQ: `mem_req_valid_o` is held with a stable address until `mem_req_ready_i`, then the FSM moves to COLLECT. If `ifill_req_kill_i` arrives before the handshake, the FSM returns to IDLE and issues no memory request.
- COLLECT: each `mem_rsp_valid_i` writes beat data at the counter index, ORs `mem_rsp_error_i` into the error flag, and increments the counter (width log2(N_BEATS), wraps to 0). The beat at index N_BEATS-1 moves the FSM to RESP.
- Kill during COLLECT moves the FSM to DRAIN. Kill in the same cycle as the last beat also moves it to IDLE, and no response is given.
- DRAIN: accepts and discards the remaining beats, then moves to IDLE. No response pulse is generated.
- RESP: `ifill_resp_valid_o`, `ifill_resp_ack_o` and `ifill_resp_error_o` are driven for exactly one cycle, then the FSM moves to IDLE. Kill in RESP is ignored.
- `ifill_resp_data_o` holds its value until the first beat of the next request overwrites it.
- `ifill_req_valid_i` outside IDLE is ignored. There is no queueing and no second ack.
- `mem_rsp_valid_i` in IDLE, REQ or RESP is ignored.

## Timing
- Reset (asynchronous): state=IDLE, counter=0. All outputs are 0, including `ifill_resp_data_o`.
- `ifill_sent_ack_o` is registered and pulses in the cycle after the request is sampled in IDLE, i.e. the first REQ cycle.
- `mem_req_valid_o` is asserted from the first REQ cycle and drops in the cycle after the handshake.
- Response latency: the response pulse appears in the cycle after the last beat is sampled. Best case is request at cycle 0, ready at cycle 1, beats at cycles 2..N_BEATS+1, response at cycle N_BEATS+2.
- Beats may have gaps (`mem_rsp_valid_i` low). The counter holds during gaps.
- Reset asserted mid-transfer returns to IDLE immediately. No response or ack is emitted after reset release.
- A new request sampled in IDLE in the cycle directly after RESP is legal: back-to-back operation with no bubble beyond RESP.

## Test plan
- Basic refill: paddr 0x00_8000_1234, ready immediately, beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles.
  - `mem_req_addr_o` = 0x00_8000_1230.
  - One `ifill_sent_ack_o` pulse.
  - Response data 0x44444444_33333333_22222222_11111111, `ifill_resp_error_o`=0, response at cycle 6.
- Backpressure and gaps: `mem_req_ready_i` low for 3 cycles, one idle cycle between each beat.
  - Address stable during backpressure.
  - Response exactly one cycle after the 4th beat; valid and ack each high for exactly 1 cycle.
- Kill in REQ: kill while ready is low.
  - `mem_req_valid_o` drops, FSM in IDLE, no response.
  - A following request completes normally.
- Kill in COLLECT: kill after beat 1 (of 4).
  - Beats 2-3 absorbed with `busy_o`=1 and no response.
  - Next request returns its own data, not stale beats.
- Error beat: `mem_rsp_error_i`=1 on beat 2 only → `ifill_resp_error_o`=1. The next clean refill → 0.
- Reset mid-COLLECT after 2 beats, plus a request asserted while busy:
  - Reset: all outputs 0 immediately; no stray ack or response after release.
  - Request while busy: produces no extra `ifill_sent_ack_o`.
